// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the FIFO-buffered UART transmitter.
// Optional feature macro: UART_TX_EVEN_PARITY_EN (8E1 framing when defined).
package uart_tx_pkg;

    // Transmit FSM states; ST_PARITY is only reachable with even parity built in.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } t_uarttx_state;

    // One text line from the upstream feeder is 34 bytes including CR/LF.
    localparam int c_line_burst_len = 34;

    // Clocks per bit, truncated toward zero.
    function automatic int f_baud_div(input int base_freq, input int baud);
        return base_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock synchronous FIFO with show-ahead read data.
// Pushes when full and pops when empty are ignored.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_full_cnt = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == c_full_cnt);
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_reg;
    // Head entry is always visible so the consumer can load it on the pop cycle.
    assign rd_data = mem[rd_ptr_reg];

    // Storage array; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (!do_push && do_pop) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_only_fifo.sv
// Byte-buffered UART transmitter: FIFO in front of an 8N1 serializer.
// Optional feature macro: UART_TX_EVEN_PARITY_EN inserts an even parity bit (8E1).
module uart_tx_only_fifo
    import uart_tx_pkg::*;
#(
    parameter int parm_BASE_FREQ  = 20_000_000,
    parameter int parm_BAUD       = 115_200,
    parameter int parm_FIFO_DEPTH = 64,
    parameter int parm_BURST_LEN  = c_line_burst_len
) (
    input  logic       i_clk_20mhz,
    input  logic       i_rst_20mhz,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_uart_txd,
    output logic       o_tx_busy,
    output logic       o_overflow
);

    localparam int c_baud_div = f_baud_div(parm_BASE_FREQ, parm_BAUD);
    localparam int BW         = $clog2(c_baud_div + 1);
    localparam int AW         = $clog2(parm_FIFO_DEPTH);
    localparam logic [BW-1:0] c_baud_last = BW'(c_baud_div - 1);
    // Highest occupancy that still leaves room for a whole line.
    localparam logic [AW:0]   c_ready_max = (AW+1)'(parm_FIFO_DEPTH - parm_BURST_LEN);

    t_uarttx_state state_reg;
    logic [BW-1:0] baud_cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          txd_reg;
    logic          ready_reg;
    logic          overflow_reg;
`ifdef UART_TX_EVEN_PARITY_EN
    logic          parity_reg;
`endif

    logic [7:0]    fifo_data;
    logic [AW:0]   fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop_en;
    logic          baud_tick;
    logic [AW:0]   count_nx;

    assign push      = i_tx_valid && !fifo_full;
    assign baud_tick = (baud_cnt_reg == c_baud_last);
    // Pop either from idle or at the very end of a stop bit, so frames run back to back.
    assign pop_en    = !fifo_empty &&
                       ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && baud_tick));

    uart_tx_fifo #(
        .DEPTH (parm_FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (i_clk_20mhz),
        .srst    (i_rst_20mhz),
        .push    (push),
        .pop     (pop_en),
        .wr_data (i_tx_data),
        .rd_data (fifo_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Occupancy after this edge, used to register the line-room flag.
    always_comb begin
        count_nx = fifo_count;
        if (push && !pop_en) begin
            count_nx = fifo_count + 1'b1;
        end else if (!push && pop_en) begin
            count_nx = fifo_count - 1'b1;
        end
    end

    // Line-room flag and sticky drop indicator.
    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            ready_reg    <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            ready_reg <= (count_nx <= c_ready_max);
            if (i_tx_valid && fifo_full) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Frame sequencer; txd is registered together with each state change.
    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            state_reg    <= ST_IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            txd_reg      <= 1'b1;
`ifdef UART_TX_EVEN_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    baud_cnt_reg <= '0;
                    bit_idx_reg  <= '0;
                    if (pop_en) begin
                        shift_reg <= fifo_data;
`ifdef UART_TX_EVEN_PARITY_EN
                        parity_reg <= ^fifo_data;
`endif
                        txd_reg   <= 1'b0;
                        state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        baud_cnt_reg <= '0;
                        txd_reg      <= shift_reg[0];
                        state_reg    <= ST_DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= bit_idx_reg + 1'b1;
                        shift_reg    <= {1'b0, shift_reg[7:1]};
                        if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_EVEN_PARITY_EN
                            txd_reg   <= parity_reg;
                            state_reg <= ST_PARITY;
`else
                            txd_reg   <= 1'b1;
                            state_reg <= ST_STOP;
`endif
                        end else begin
                            txd_reg <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
`ifdef UART_TX_EVEN_PARITY_EN
                ST_PARITY: begin
                    if (baud_tick) begin
                        baud_cnt_reg <= '0;
                        txd_reg      <= 1'b1;
                        state_reg    <= ST_STOP;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_tick) begin
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        if (pop_en) begin
                            shift_reg <= fifo_data;
`ifdef UART_TX_EVEN_PARITY_EN
                            parity_reg <= ^fifo_data;
`endif
                            txd_reg   <= 1'b0;
                            state_reg <= ST_START;
                        end else begin
                            txd_reg   <= 1'b1;
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    baud_cnt_reg <= '0;
                    txd_reg      <= 1'b1;
                    state_reg    <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_uart_txd = txd_reg;
    assign o_tx_ready = ready_reg;
    assign o_overflow = overflow_reg;
    assign o_tx_busy  = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_only_fifo.sv
// Self-checking bench for uart_tx_only_fifo: directed steps with random data,
// a byte queue as reference model and a line monitor that decodes frames.
// Build with UART_TX_EVEN_PARITY_EN defined to exercise 8E1 framing.
module tb_uart_tx_only_fifo;

    localparam int DIV   = 20_000_000 / 115_200;
    localparam int DEPTH = 64;
    localparam int BURST = 34;
`ifdef UART_TX_EVEN_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = NBITS * DIV;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       ready;
    logic       txd;
    logic       busy;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    // Reference model: bytes accepted but not yet started on the line.
    logic [7:0] q[$];
    bit         ovf_exp      = 1'b0;
    bit         mon_en       = 1'b0;
    bit         in_frame     = 1'b0;
    bit         expect_start = 1'b0;
    int         pos          = 0;
    logic [NBITS-1:0] cur_frame;
    logic [7:0] cur_byte;
    logic [7:0] rx_byte;

    uart_tx_only_fifo dut (
        .i_clk_20mhz (clk),
        .i_rst_20mhz (rst),
        .i_tx_data   (data),
        .i_tx_valid  (valid),
        .o_tx_ready  (ready),
        .o_uart_txd  (txd),
        .o_tx_busy   (busy),
        .o_overflow  (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line levels of one frame, bit 0 first: start, data LSB first, [parity], stop.
    function automatic logic [NBITS-1:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_EVEN_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    // Line monitor: decodes frames and checks every cycle against the model.
    always @(negedge clk) begin
        if (!mon_en || rst) begin
            in_frame     = 1'b0;
            expect_start = 1'b0;
        end else begin
            if (expect_start) begin
                chk("gapless_start", txd, 1'b0);
                expect_start = 1'b0;
            end
            if (!in_frame && txd === 1'b0) begin
                chk("start_has_data", (q.size() != 0), 1'b1);
                if (q.size() != 0) begin
                    cur_byte  = q.pop_front();
                    cur_frame = frame_of(cur_byte);
                    in_frame  = 1'b1;
                    pos       = 0;
                    rx_byte   = 8'h00;
                end
            end
            if (in_frame) begin
                chk("txd_bit", txd, cur_frame[pos / DIV]);
                if ((pos % DIV) == DIV / 2 && pos / DIV >= 1 && pos / DIV <= 8) begin
                    rx_byte[pos / DIV - 1] = txd;
                end
            end
            chk("busy", busy, (in_frame || q.size() != 0));
            chk("ready", ready, ((DEPTH - q.size()) >= BURST));
            chk("overflow", ovf, ovf_exp);
            if (in_frame) begin
                if (pos == FL - 1) begin
                    in_frame = 1'b0;
                    chk("rx_byte", rx_byte, cur_byte);
                    $display("RX byte=%02h expected=%02h", rx_byte, cur_byte);
                    expect_start = (q.size() != 0);
                end else begin
                    pos++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One valid cycle; the model accepts the byte if the FIFO held fewer than DEPTH.
    task automatic push(input logic [7:0] b);
        valid = 1'b1;
        data  = b;
        @(posedge clk);
        #1;
        if (q.size() < DEPTH) begin
            q.push_back(b);
            $display("TX push byte=%02h queued=%0d", b, q.size());
        end else begin
            ovf_exp = 1'b1;
            $display("TX push byte=%02h dropped, fifo full", b);
        end
        valid = 1'b0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b1;
        data  = 8'($urandom);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        valid   = 1'b0;
        ovf_exp = 1'b0;
        q.delete();
        chk("rst_txd", txd, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", ready, 1'b1);
        chk("rst_overflow", ovf, 1'b0);
        $display("RESET applied");
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && (q.size() != 0 || in_frame); i++) tick(1);
        chk("drain_in_time", (q.size() == 0 && !in_frame), 1'b1);
        chk("busy_after_drain", busy, 1'b0);
    endtask

    initial begin
        logic [7:0] b;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        mon_en = 1'b1;
        tick(3);

        // Single byte: two-clock latency to the start bit, then the full frame.
        push(8'h55);
        chk("latency_still_idle", txd, 1'b1);
        tick(1);
        chk("latency_start_bit", txd, 1'b0);
        wait_drain(2 * FL);
        tick(5);

        // One full text line back to back.
        for (int i = 0; i < BURST; i++) begin
            b = (i < BURST - 2) ? 8'(8'h30 + i) : ((i == BURST - 2) ? 8'h0d : 8'h0a);
            push(b);
        end
        chk("ready_low_after_line", ready, 1'b0);
        wait_drain((BURST + 2) * FL);
        chk("ready_back_high", ready, 1'b1);

        // Push during the stop bit of a running frame: next frame follows with no gap.
        push(8'($urandom));
        for (int i = 0; i < 2 * FL && !(in_frame && pos >= (NBITS - 1) * DIV + 5); i++) tick(1);
        chk("reached_stop_bit", (in_frame && pos >= (NBITS - 1) * DIV + 5), 1'b1);
        push(8'($urandom));
        wait_drain(3 * FL);

`ifdef UART_TX_EVEN_PARITY_EN
        // Parity polarity: 0x07 carries 1, 0x03 carries 0.
        push(8'h07);
        push(8'h03);
        wait_drain(3 * FL);
`endif

        // Overflow: far more bytes than the FIFO can hold before a frame completes.
        for (int i = 0; i < 70; i++) push(8'($urandom));
        chk("overflow_set", ovf, 1'b1);
        chk("ready_when_full", ready, 1'b0);
        tick(50);
        chk("overflow_sticky", ovf, 1'b1);
        do_reset();
        tick(5);

        // Reset in the middle of data bit 3 of 0xA3 abandons the frame.
        push(8'hA3);
        tick(1 + 4 * DIV + DIV / 2);
        chk("mid_bit3_level", txd, 1'b0);
        do_reset();
        tick(DIV);
        chk("idle_after_abort", txd, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
